// File: rtl/dds_multi_wave_if.sv
// rtl/dds_multi_wave_if.sv - configuration bus for the multi-channel DDS generator
interface dds_multi_wave_if #(
  parameter int CH_W    = 4,
  parameter int PHASE_W = 32
) ();
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [2:0]         cfg_reg;
  logic [PHASE_W-1:0] cfg_data;
  logic               cfg_commit;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_reg,
    output cfg_data,
    output cfg_commit
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_reg,
    input cfg_data,
    input cfg_commit
  );
endinterface

// File: rtl/dds_multi_wave.sv
// rtl/dds_multi_wave.sv - multi-channel arithmetic DDS with shadowed config and 3-stage output pipeline
module dds_multi_wave #(
  parameter int NUM_CH         = 16,
  parameter int PHASE_W        = 32,
  parameter int OUT_W          = 16,
  parameter int OUT_OFFSET_BIN = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sync,
  dds_multi_wave_if.slave         cfg,
  output logic [NUM_CH*OUT_W-1:0] dout,
  output logic                    dout_valid
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [OUT_W-1:0] MSB_ONLY = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] POS_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_XOR  = (OUT_OFFSET_BIN != 0) ? MSB_ONLY : '0;
  localparam logic [OUT_W-1:0] RST_OUT  = OUT_XOR;

  typedef struct packed {
    logic [PHASE_W-1:0] freq;
    logic [OUT_W-1:0]   phase;
    logic [OUT_W-1:0]   amp;
    logic [OUT_W-1:0]   offset;
    logic [1:0]         mode;
  } cfg_t;

  cfg_t               sh_q   [NUM_CH];
  cfg_t               sh_d   [NUM_CH];
  cfg_t               act_q  [NUM_CH];
  cfg_t               act_d  [NUM_CH];
  logic [PHASE_W-1:0] acc_q  [NUM_CH];
  logic [PHASE_W-1:0] acc_d  [NUM_CH];
  logic [OUT_W-1:0]   w1_q   [NUM_CH];
  logic [OUT_W-1:0]   w1_d   [NUM_CH];
  logic [OUT_W-1:0]   amp1_q [NUM_CH];
  logic [OUT_W-1:0]   amp1_d [NUM_CH];
  logic [OUT_W-1:0]   off1_q [NUM_CH];
  logic [OUT_W-1:0]   off1_d [NUM_CH];
  logic [OUT_W-1:0]   s2_q   [NUM_CH];
  logic [OUT_W-1:0]   s2_d   [NUM_CH];
  logic [OUT_W-1:0]   off2_q [NUM_CH];
  logic [OUT_W-1:0]   off2_d [NUM_CH];
  logic [OUT_W-1:0]   y3_q   [NUM_CH];
  logic [OUT_W-1:0]   y3_d   [NUM_CH];
  logic [2:0]         vld_q;
  logic [2:0]         vld_d;

  // Phase word to signed waveform sample; MSB inversion maps unsigned ramps onto signed range.
  function automatic logic [OUT_W-1:0] gen_wave(input logic [OUT_W-1:0] p, input logic [1:0] mode);
    logic [OUT_W-1:0] q;
    logic [OUT_W-1:0] tw;
    logic [OUT_W-1:0] w;
    q  = {p[OUT_W-2:0], 1'b0};
    tw = p[OUT_W-1] ? ~q : q;
    case (mode)
      2'd0:    w = {~tw[OUT_W-1], tw[OUT_W-2:0]};
      2'd1:    w = {~p[OUT_W-1], p[OUT_W-2:0]};
      2'd2:    w = p[OUT_W-1] ? MSB_ONLY : POS_MAX;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Signed sample times unsigned amplitude, keeping the upper half with round-half-up.
  function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0] w, input logic [OUT_W-1:0] amp);
    logic signed [2*OUT_W:0] prod;
    prod = $signed({{(OUT_W+1){w[OUT_W-1]}}, w}) * $signed({{(OUT_W+1){1'b0}}, amp});
    return prod[2*OUT_W-1:OUT_W] + {{(OUT_W-1){1'b0}}, prod[OUT_W-1]};
  endfunction

  // Signed add with one guard bit, clamped to the representable output range.
  function automatic logic [OUT_W-1:0] sat_add(input logic [OUT_W-1:0] s, input logic [OUT_W-1:0] o);
    logic [OUT_W:0]   t;
    logic [OUT_W-1:0] r;
    t = {s[OUT_W-1], s} + {o[OUT_W-1], o};
    if (t[OUT_W] != t[OUT_W-1]) begin
      r = t[OUT_W] ? MSB_ONLY : POS_MAX;
    end else begin
      r = t[OUT_W-1:0];
    end
    return r;
  endfunction

  // Shadow writes and atomic commit; commit copies the pre-edge shadow so a same-cycle write waits.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sh_d[c]  = sh_q[c];
      act_d[c] = cfg.cfg_commit ? sh_q[c] : act_q[c];
      if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(c))) begin
        case (cfg.cfg_reg)
          3'd0:    sh_d[c].freq   = cfg.cfg_data;
          3'd1:    sh_d[c].phase  = cfg.cfg_data[OUT_W-1:0];
          3'd2:    sh_d[c].amp    = cfg.cfg_data[OUT_W-1:0];
          3'd3:    sh_d[c].offset = cfg.cfg_data[OUT_W-1:0];
          3'd4:    sh_d[c].mode   = cfg.cfg_data[1:0];
          default: ;
        endcase
      end
    end
  end

  // Phase accumulators (sync wins over enable) and the three datapath stages; config rides along.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (sync) begin
        acc_d[c] = '0;
      end else if (enable) begin
        acc_d[c] = acc_q[c] + act_q[c].freq;
      end else begin
        acc_d[c] = acc_q[c];
      end
      w1_d[c]   = gen_wave(acc_q[c][PHASE_W-1 -: OUT_W] + act_q[c].phase, act_q[c].mode);
      amp1_d[c] = act_q[c].amp;
      off1_d[c] = act_q[c].offset;
      s2_d[c]   = scale(w1_q[c], amp1_q[c]);
      off2_d[c] = off1_q[c];
      y3_d[c]   = sat_add(s2_q[c], off2_q[c]) ^ OUT_XOR;
    end
    vld_d = {vld_q[1:0], enable};
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sh_q[c]   <= '0;
        act_q[c]  <= '0;
        acc_q[c]  <= '0;
        w1_q[c]   <= '0;
        amp1_q[c] <= '0;
        off1_q[c] <= '0;
        s2_q[c]   <= '0;
        off2_q[c] <= '0;
        y3_q[c]   <= RST_OUT;
      end
      vld_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        sh_q[c]   <= sh_d[c];
        act_q[c]  <= act_d[c];
        acc_q[c]  <= acc_d[c];
        w1_q[c]   <= w1_d[c];
        amp1_q[c] <= amp1_d[c];
        off1_q[c] <= off1_d[c];
        s2_q[c]   <= s2_d[c];
        off2_q[c] <= off2_d[c];
        y3_q[c]   <= y3_d[c];
      end
      vld_q <= vld_d;
    end
  end

  // Pack the per-channel outputs onto the DAC lanes.
  always_comb begin
    dout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dout[c*OUT_W +: OUT_W] = y3_q[c];
    end
    dout_valid = vld_q[2];
  end

endmodule
